// File: rtl/tape_pkg.sv
// Shared types and helpers for the CSW tape player: FSM state encoding,
// accumulator width and FIFO pointer-width helper.
package tape_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    FETCH,
    EXT0,
    EXT1,
    EXT2,
    EXT3,
    RUN
  } tape_state_t;

  function automatic int clog2_depth(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/tape_fifo.sv
// Single-clock byte FIFO with registered write; reset flushes the contents.
module tape_fifo
  import tape_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = clog2_depth(DEPTH)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/csw_tape_player.sv
// CSW v1 RLE body player: buffers body bytes and regenerates the tape square wave.
// Define CSW_EXT_LEN_EN to include the 0-byte + 32-bit little-endian extended length path.
module csw_tape_player
  import tape_pkg::*;
#(
  parameter int CLK_HZ     = 64000000,
  parameter int SAMPLE_HZ  = 44100,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       play,
  input  logic       motor,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tape_out,
  output logic       active,
  output logic       underrun
);
  localparam int AW = clog2_depth(FIFO_DEPTH);
  localparam logic [ACC_W-1:0] CLK_STEP = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] SMP_STEP = ACC_W'(SAMPLE_HZ);

  logic             run, tick, dec, pop, pend;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_data;
  logic [AW:0]      fifo_level;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [31:0]      cnt;
  tape_state_t      state, state_nxt;
`ifdef CSW_EXT_LEN_EN
  logic [23:0]      len;
`endif

  assign run      = play & motor;
  assign acc_sum  = acc + SMP_STEP;
  assign tick     = run & (acc_sum >= CLK_STEP);
  // A tick that landed during turnaround counts as this pulse's decrement.
  assign dec      = run & (tick | pend);
  assign in_ready = ~fifo_full;

  always_ff @(posedge clk_sys) begin
    if (reset)    acc <= '0;
    else if (run) acc <= tick ? (acc_sum - CLK_STEP) : acc_sum;
  end

  tape_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_level)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (run && !fifo_empty) begin
`ifdef CSW_EXT_LEN_EN
        state_nxt = (fifo_data == 8'd0) ? EXT0 : RUN;
`else
        state_nxt = RUN;
`endif
      end
`ifdef CSW_EXT_LEN_EN
      EXT0: if (run && !fifo_empty) state_nxt = EXT1;
      EXT1: if (run && !fifo_empty) state_nxt = EXT2;
      EXT2: if (run && !fifo_empty) state_nxt = EXT3;
      EXT3: if (run && !fifo_empty) state_nxt = ({fifo_data, len} == 32'd0) ? FETCH : RUN;
`endif
      RUN:   if (dec && cnt == 32'd1) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    active = 1'b0;
    case (state)
      FETCH: pop = run & ~fifo_empty;
      EXT0, EXT1, EXT2, EXT3: begin
        pop    = run & ~fifo_empty;
        active = 1'b1;
      end
      RUN:   active = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tape_out <= 1'b0;
      underrun <= 1'b0;
      pend     <= 1'b0;
    end else begin
      if (run && state != RUN && fifo_level == '0) underrun <= 1'b1;
      if (state == RUN) begin
        if (run) pend <= pend & tick;
        if (dec && cnt == 32'd1) tape_out <= ~tape_out;
      end else if (tick) begin
        pend <= 1'b1;
      end
    end
  end

  // Pulse length and extended-length bytes carry no reset; FETCH reloads them.
  always_ff @(posedge clk_sys) begin
    case (state)
`ifdef CSW_EXT_LEN_EN
      FETCH: if (pop) cnt <= {24'd0, fifo_data};
      EXT0:  if (pop) len[7:0]   <= fifo_data;
      EXT1:  if (pop) len[15:8]  <= fifo_data;
      EXT2:  if (pop) len[23:16] <= fifo_data;
      EXT3:  if (pop) cnt <= {fifo_data, len};
`else
      FETCH: if (pop) cnt <= (fifo_data == 8'd0) ? 32'd256 : {24'd0, fifo_data};
`endif
      RUN:   if (dec) cnt <= cnt - 32'd1;
      default: ;
    endcase
  end

endmodule
